// File: rtl/mat_mult_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// The narrowing helper works on a fixed wide word so it can serve any width.
package mat_mult_pkg;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   localparam int NARROW_W = 64;

   function automatic int acc_w(input int n, input int data_w);
      return 2 * data_w + $clog2(n);
   endfunction

   // x arrives already sign- or zero-extended to NARROW_W; returns {ovf, value}.
   function automatic logic [NARROW_W:0] narrow(input logic [NARROW_W-1:0] x,
                                                input int out_w,
                                                input int is_signed,
                                                input int saturate);
      logic [NARROW_W-1:0] mask;
      logic [NARROW_W-1:0] hi;
      logic [NARROW_W-1:0] lo;
      logic [NARROW_W-1:0] v;
      logic                o;
      mask = (NARROW_W'(1) << out_w) - NARROW_W'(1);
      v    = x;
      if (is_signed != 0) begin
         hi = mask >> 1;
         lo = ~hi;
         o  = ($signed(x) > $signed(hi)) || ($signed(x) < $signed(lo));
         if (o && saturate != 0) v = x[NARROW_W-1] ? lo : hi;
      end else begin
         hi = mask;
         lo = '0;
         o  = x > hi;
         if (o && saturate != 0) v = hi;
      end
      return {o, v & mask};
   endfunction

endpackage

// File: rtl/mat_mac_unit.sv
// Multiply-accumulate lane: registered accumulator with clear/enable, plus the
// narrowed view of the next accumulator value and its overflow flag.
module mat_mac_unit
   import mat_mult_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 18,
   parameter int OUT_W    = 8,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [OUT_W-1:0]  q,
   output logic              q_ovf
);

   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_next;
   logic [ACC_W-1:0]    a_ext;
   logic [ACC_W-1:0]    b_ext;
   logic [NARROW_W-1:0] x_ext;
   logic [NARROW_W:0]   nr;
   logic                unused_hi;

   // Extending both operands to ACC_W first makes the low ACC_W product bits correct either way.
   if (SIGNED != 0) begin : g_sext
      assign a_ext = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
      assign b_ext = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
      assign x_ext = {{(NARROW_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};
   end else begin : g_zext
      assign a_ext = {{(ACC_W-DATA_W){1'b0}}, a};
      assign b_ext = {{(ACC_W-DATA_W){1'b0}}, b};
      assign x_ext = {{(NARROW_W-ACC_W){1'b0}}, acc_next};
   end

   assign acc_next  = acc + a_ext * b_ext;
   assign nr        = narrow(x_ext, OUT_W, SIGNED, SATURATE);
   assign q         = nr[OUT_W-1:0];
   assign q_ovf     = nr[NARROW_W];
   assign unused_hi = ^nr[NARROW_W-1:OUT_W];

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc_next;
   end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential NxN matrix multiplier C = A x B, one MAC per cycle, with
// start/busy/done handshake, abort, and saturating or wrapping narrowing.
module mat_mult_seq
   import mat_mult_pkg::*;
#(
   parameter int N        = 3,
   parameter int DATA_W   = 8,
   parameter int OUT_W    = 8,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [N*N*DATA_W-1:0] a_flat,
   input  logic [N*N*DATA_W-1:0] b_flat,
   output logic [N*N*OUT_W-1:0]  c_flat,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);

   localparam int ACC_W = acc_w(N, DATA_W);
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   state_t                state_q, state_d;
   logic [N*N*DATA_W-1:0] a_r, b_r;
   logic [N*N*OUT_W-1:0]  c_r;
   logic [IDX_W-1:0]      i, j, k;
   logic                  ovf_acc;
   logic                  capture, step, k_last, last;
   logic [OUT_W-1:0]      mac_q;
   logic                  mac_ovf;
   int                    a_sel, b_sel, c_sel;

   assign capture = (state_q == IDLE) && start && !abort;
   assign step    = (state_q == MAC) && !abort;
   assign k_last  = (k == LAST);
   assign last    = k_last && (j == LAST) && (i == LAST);
   assign busy    = (state_q != IDLE);
   assign a_sel   = int'(i) * N + int'(k);
   assign b_sel   = int'(k) * N + int'(j);
   assign c_sel   = int'(i) * N + int'(j);

   mat_mac_unit #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .OUT_W    (OUT_W),
      .SIGNED   (SIGNED),
      .SATURATE (SATURATE)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (capture || (step && k_last)),
      .en    (step),
      .a     (a_r[a_sel*DATA_W +: DATA_W]),
      .b     (b_r[b_sel*DATA_W +: DATA_W]),
      .q     (mac_q),
      .q_ovf (mac_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture) state_d = MAC;
         MAC:     if (abort) state_d = IDLE;
                  else if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the operand/result storage is reset as well, so a job aborted by
   // reset can never leak stale data into a later commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         c_r     <= '0;
         i       <= '0;
         j       <= '0;
         k       <= '0;
         ovf_acc <= 1'b0;
         c_flat  <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= (state_q == DONE);
         if (capture) begin
            a_r     <= a_flat;
            b_r     <= b_flat;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            ovf_acc <= 1'b0;
         end else if (step) begin
            if (k_last) begin
               c_r[c_sel*OUT_W +: OUT_W] <= mac_q;
               ovf_acc <= ovf_acc | mac_ovf;
               k <= '0;
               if (j == LAST) begin
                  j <= '0;
                  i <= (i == LAST) ? '0 : i + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end else begin
               k <= k + 1'b1;
            end
         end
         if (state_q == DONE) begin
            c_flat <= c_r;
            ovf    <= ovf_acc;
         end
      end
   end

endmodule
